// File: rtl/temp_monitor_pkg.sv
// Shared types and seven-segment glyphs for the temperature monitor.
// Segment bit order is {dp,g,f,e,d,c,b,a}, active low.
package temp_monitor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FAN   = 2'd1,
        ST_ALARM = 2'd2
    } state_t;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Non-decimal glyph codes share the 4-bit code space with BCD digits
    localparam logic [3:0] CODE_A     = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hB;
    localparam logic [3:0] CODE_DASH  = 4'hE;
    localparam logic [3:0] CODE_F     = 4'hF;

    function automatic logic [7:0] seg_of(input logic [3:0] code);
        logic [7:0] seg;
        case (code)
            4'd0:       seg = SEG_0;
            4'd1:       seg = SEG_1;
            4'd2:       seg = SEG_2;
            4'd3:       seg = SEG_3;
            4'd4:       seg = SEG_4;
            4'd5:       seg = SEG_5;
            4'd6:       seg = SEG_6;
            4'd7:       seg = SEG_7;
            4'd8:       seg = SEG_8;
            4'd9:       seg = SEG_9;
            CODE_A:     seg = SEG_A;
            CODE_F:     seg = SEG_F;
            CODE_DASH:  seg = SEG_DASH;
            default:    seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/temp_monitor_display_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter, one bit per clock.
// A start while busy discards the running conversion and reloads.
import temp_monitor_pkg::*;

module bin2bcd_seq #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] bin,
    output logic         busy,
    output logic         done,
    output logic [11:0]  bcd
);

    localparam int SW = 12 + W;
    localparam int CW = $clog2(W + 1);

    logic [SW-1:0] work;
    logic [SW-1:0] work_nx;
    logic [CW-1:0] cnt;

    always_comb begin
        work_nx = work;
        for (int i = 0; i < 3; i++) begin
            if (work_nx[W+4*i +: 4] >= 4'd5)
                work_nx[W+4*i +: 4] = work_nx[W+4*i +: 4] + 4'd3;
        end
        work_nx = work_nx << 1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            bcd  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                work <= {12'b0, bin};
                cnt  <= CW'(W);
                busy <= 1'b1;
            end else if (busy) begin
                work <= work_nx;
                cnt  <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    bcd  <= work_nx[SW-1:W];
                end
            end
        end
    end

endmodule

// File: rtl/temp_monitor_display.sv
// Temperature supervisor: hysteresis fan/alarm FSM plus a multiplexed
// common-anode readout of the last sample and a status glyph.
import temp_monitor_pkg::*;

module temp_monitor_display #(
    parameter int TEMP_W      = 5,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int FAN_ON      = 20,
    parameter int FAN_OFF     = 18,
    parameter int ALARM_ON    = 28,
    parameter int ALARM_OFF   = 26
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [TEMP_W-1:0] temperatura,
    input  logic              en_m1,
    input  logic              lect,
    output logic              est_alarma,
    output logic              est_ventilador,
    output logic [DIGITS-1:0] anodos,
    output logic [7:0]        catodos
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(DIGITS);

    logic [TEMP_W-1:0] t_reg;
    state_t            state;
    state_t            state_nx;
    logic [11:0]       disp_bcd;
    logic [CW-1:0]     ref_cnt;
    logic [IW-1:0]     dig_idx;
    logic              cap;
    logic [11:0]       conv_bcd;
    logic              conv_busy;
    logic              conv_done;
    logic [3:0]        code;

    assign cap = lect & en_m1;

    bin2bcd_seq #(.W(TEMP_W)) u_bcd (
        .clk   (clock),
        .rst_n (reset),
        .start (cap),
        .bin   (temperatura),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            t_reg    <= '0;
            state    <= ST_IDLE;
            disp_bcd <= '0;
            ref_cnt  <= '0;
            dig_idx  <= '0;
        end else begin
            if (cap)
                t_reg <= temperatura;
            state <= state_nx;
            if (conv_done && !conv_busy)
                disp_bcd <= conv_bcd;
            if (ref_cnt == CW'(REFRESH_DIV - 1)) begin
                ref_cnt <= '0;
                if (dig_idx == IW'(DIGITS - 1))
                    dig_idx <= '0;
                else
                    dig_idx <= dig_idx + 1'b1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        if (!en_m1) begin
            state_nx = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (t_reg >= TEMP_W'(ALARM_ON))
                        state_nx = ST_ALARM;
                    else if (t_reg >= TEMP_W'(FAN_ON))
                        state_nx = ST_FAN;
                end
                ST_FAN: begin
                    if (t_reg >= TEMP_W'(ALARM_ON))
                        state_nx = ST_ALARM;
                    else if (t_reg <= TEMP_W'(FAN_OFF))
                        state_nx = ST_IDLE;
                end
                ST_ALARM: begin
                    if (t_reg <= TEMP_W'(FAN_OFF))
                        state_nx = ST_IDLE;
                    else if (t_reg <= TEMP_W'(ALARM_OFF))
                        state_nx = ST_FAN;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    assign est_ventilador = (state != ST_IDLE);
    assign est_alarma     = (state == ST_ALARM);

    // Leading-zero blanking: tens blank only when hundreds is also zero
    always_comb begin
        code = CODE_BLANK;
        if (dig_idx == IW'(0)) begin
            code = disp_bcd[3:0];
        end else if (dig_idx == IW'(1)) begin
            if (disp_bcd[11:4] != 8'd0)
                code = disp_bcd[7:4];
        end else if (dig_idx == IW'(2)) begin
            if (disp_bcd[11:8] != 4'd0)
                code = disp_bcd[11:8];
        end else if (dig_idx == IW'(3)) begin
            if (!en_m1)
                code = CODE_BLANK;
            else if (state == ST_ALARM)
                code = CODE_A;
            else if (state == ST_FAN)
                code = CODE_F;
            else
                code = CODE_DASH;
        end
    end

    assign catodos = seg_of(code);
    assign anodos  = ~(DIGITS'(1) << dig_idx);

endmodule

// File: tb/tb_temp_monitor_display.sv
// Directed scoreboard bench for temp_monitor_display with a fast refresh.
// Expected values are queued as stimulus is applied and popped at sampling.
module tb_temp_monitor_display;

    localparam int TW = 5;
    localparam int DG = 4;
    localparam int RD = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [TW-1:0] temperatura = '0;
    logic          en_m1 = 1'b1;
    logic          lect = 1'b0;
    logic          est_alarma;
    logic          est_ventilador;
    logic [DG-1:0] anodos;
    logic [7:0]    catodos;

    temp_monitor_display #(
        .TEMP_W      (TW),
        .DIGITS      (DG),
        .REFRESH_DIV (RD),
        .FAN_ON      (20),
        .FAN_OFF     (18),
        .ALARM_ON    (28),
        .ALARM_OFF   (26)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .temperatura    (temperatura),
        .en_m1          (en_m1),
        .lect           (lect),
        .est_alarma     (est_alarma),
        .est_ventilador (est_ventilador),
        .anodos         (anodos),
        .catodos        (catodos)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [7:0] glyph(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            5: return 8'h92;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    // Expected glyph on display digits 0..2 for a shown value below 100
    function automatic logic [7:0] num_glyph(input int idx, input int v);
        if (idx == 0) return glyph(v % 10);
        if (idx == 1) return (v >= 10) ? glyph(v / 10) : 8'hFF;
        return 8'hFF;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed %0h", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", e.tag, obs, e.val);
        end
    endtask

    task automatic strobe(input int t);
        temperatura = TW'(t);
        lect = 1'b1;
        tick();
        lect = 1'b0;
    endtask

    task automatic chk_outs(input string tag, input logic fan, input logic alm);
        push({tag, "_fan"}, {31'd0, fan});
        pop_check({31'd0, est_ventilador});
        push({tag, "_alarm"}, {31'd0, alm});
        pop_check({31'd0, est_alarma});
    endtask

    task automatic read_digit(input int i, input string tag, input logic [7:0] exp);
        logic [7:0]    obs;
        logic [DG-1:0] sel;
        obs = 'x;
        sel = DG'(1) << i;
        push(tag, {24'd0, exp});
        for (int k = 0; k < 24; k++) begin
            if (anodos === ~sel) begin
                obs = catodos;
                break;
            end
            tick();
        end
        pop_check({24'd0, obs});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        logic [DG-1:0] sel;

        // Reset state and refresh rotation
        repeat (3) tick();
        chk_outs("rst", 1'b0, 1'b0);
        push("rst_anodos", 32'h0000_000E);
        pop_check({28'd0, anodos});
        push("rst_catodos", 32'h0000_00C0);
        pop_check({24'd0, catodos});
        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            sel = DG'(1) << ((k / 4) % 4);
            push($sformatf("refresh_%0d", k), {28'd0, ~sel});
            pop_check({28'd0, anodos});
        end

        // Hysteresis walk
        strobe(19); tick(); chk_outs("t19", 1'b0, 1'b0);
        strobe(20); chk_outs("t20_lat", 1'b0, 1'b0);
        tick(); chk_outs("t20", 1'b1, 1'b0);
        strobe(28); tick(); chk_outs("t28", 1'b1, 1'b1);
        strobe(27); tick(); chk_outs("t27", 1'b1, 1'b1);
        strobe(26); tick(); chk_outs("t26", 1'b1, 1'b0);
        strobe(19); tick(); chk_outs("t19b", 1'b1, 1'b0);
        strobe(18); tick(); chk_outs("t18", 1'b0, 1'b0);

        // Direct jump to alarm and display content
        strobe(31); chk_outs("t31_lat", 1'b0, 1'b0);
        tick(); chk_outs("t31", 1'b1, 1'b1);
        repeat (5) tick();
        read_digit(0, "d31_units", 8'hF9);
        read_digit(1, "d31_tens", 8'hB0);
        read_digit(2, "d31_hund", 8'hFF);
        read_digit(3, "d31_stat", 8'h88);

        // Enable drop, ignored strobe, then re-enable
        en_m1 = 1'b0;
        tick(); chk_outs("dis", 1'b0, 1'b0);
        read_digit(3, "dis_stat", 8'hFF);
        strobe(5);
        repeat (8) tick();
        read_digit(0, "dis_units", 8'hF9);
        read_digit(1, "dis_tens", 8'hB0);
        chk_outs("dis_hold", 1'b0, 1'b0);
        en_m1 = 1'b1;
        tick(); chk_outs("reen", 1'b1, 1'b1);

        // Conversion restart: 9 is aborted, 25 lands TW+1 clocks later
        strobe(9);
        tick();
        strobe(25);
        for (int c = 1; c <= TW + 1; c++) begin
            tick();
            push($sformatf("onehot_%0d", c), 32'd1);
            pop_check($countones(~anodos));
            idx = -1;
            for (int j = 0; j < DG; j++)
                if (anodos[j] === 1'b0) idx = j;
            if (idx >= 0 && idx < 3) begin
                push($sformatf("restart_c%0d_d%0d", c, idx),
                     {24'd0, num_glyph(idx, (c <= TW) ? 31 : 25)});
                pop_check({24'd0, catodos});
            end
        end
        chk_outs("t25", 1'b1, 1'b0);
        read_digit(0, "d25_units", 8'h92);
        read_digit(1, "d25_tens", 8'hA4);
        read_digit(2, "d25_hund", 8'hFF);
        read_digit(3, "d25_stat", 8'h8E);

        // Reset during FAN with a conversion in flight
        strobe(22);
        reset = 1'b0;
        tick();
        chk_outs("mrst", 1'b0, 1'b0);
        push("mrst_anodos", 32'h0000_000E);
        pop_check({28'd0, anodos});
        push("mrst_catodos", 32'h0000_00C0);
        pop_check({24'd0, catodos});
        tick();
        reset = 1'b1;
        repeat (12) tick();
        chk_outs("post_rst", 1'b0, 1'b0);
        read_digit(0, "prst_units", 8'hC0);
        read_digit(1, "prst_tens", 8'hFF);
        read_digit(3, "prst_stat", 8'hBF);

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL sb_leftover observed %0d expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
